kbd_matrix: RTL
===============

KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 Parameter HOLD_CYC, default 16'd50000, minimum number of CLK cycles a key stays pressed after a make event before a queued break for any key may apply.
REQ-002 Parameter FIFO_DEPTH, default 4, number of event FIFO entries; legal values are powers of two from 2 to 16.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST_n  input  1  reset, asynchronous, active-high.
REQ-005 EV_VALID  input  1  host key event valid.
REQ-006 EV_READY  output  1  block can accept an event.
REQ-007 EV_CODE  input  7  key code: [6:3] row 0-15, [2:0] column 0-7.
REQ-008 EV_MAKE  input  1  1 = key press, 0 = key release.
REQ-009 EV_CLR  input  1  single-cycle all-keys-release and flush request.
REQ-010 ROW_SEL  input  4  row select from PIO port A bits [3:0].
REQ-011 STROBE  input  1  scan enable from PIO port A bit 4.
REQ-012 COL_n  output  8  column data to PIO port B; active-low, 0 = pressed.
REQ-013 ANY_KEY  output  1  registered OR of all matrix bits.

Function
REQ-014 The block shall hold a 16x8 key matrix, with bit = 1 meaning pressed.
REQ-015 The FIFO shall store {EV_CODE, EV_MAKE}, with EV_READY = 1 exactly when the FIFO is not full and EV_CLR = 0.
REQ-016 A push shall occur on any edge where EV_VALID = 1 and EV_READY = 1, and EV_CODE/EV_MAKE shall be sampled on that edge.
REQ-017 The FSM shall have states IDLE, APPLY and WAIT, and shall enter IDLE on reset.
REQ-018 In IDLE, the FSM shall go to APPLY on the next edge when the FIFO is non-empty; otherwise it shall stay in IDLE.
REQ-019 In APPLY with a make at the FIFO head, the FSM shall set the matrix bit, load the hold counter with HOLD_CYC, pop the head and go to IDLE.
REQ-020 In APPLY with a break at the head and hold counter = 0, the FSM shall clear the matrix bit, pop the head and go to IDLE.
REQ-021 In APPLY with a break at the head and hold counter != 0, the FSM shall go to WAIT without popping.
REQ-022 In WAIT, the FSM shall go to APPLY on the edge where the hold counter reaches 0.
REQ-023 The hold counter shall decrement by 1 every cycle while non-zero, in every state, and shall saturate at 0; a load takes precedence over a decrement.
REQ-024 A make for an already-pressed key, or a break for an already-released key, shall be popped normally and shall leave the matrix unchanged.
REQ-025 Latency: for an event pushed at edge t into an empty FIFO with FSM in IDLE, the matrix shall update at edge t+2 and COL_n shall reflect the update at edge t+3.
REQ-026 A simultaneous push and pop in the same cycle shall be legal, and the FIFO count shall be unchanged.
REQ-027 Events shall apply strictly in FIFO order; a break waiting at the head shall block all later events.
REQ-028 When EV_CLR = 1 on an edge, the block shall zero the matrix, empty the FIFO, zero the hold counter and force the FSM to IDLE.
REQ-029 EV_CLR shall override any simultaneous push, pop or apply, and no event shall be accepted on that edge.
REQ-030 COL_n shall be a register loaded each edge with ~matrix[ROW_SEL] when STROBE = 1, and with 8'hFF when STROBE = 0.
REQ-031 ANY_KEY shall be a register loaded each edge with the OR of all 128 matrix bits.
REQ-032 FIFO read and write pointers shall wrap modulo FIFO_DEPTH, and full/empty shall be distinguished by an extra pointer bit.

Reset
REQ-033 While RST_n = 1, asynchronously: matrix = 0, FIFO empty, hold counter = 0, FSM = IDLE, COL_n = 8'hFF, ANY_KEY = 0, EV_READY = 0.
REQ-034 On the first edge after RST_n deasserts, EV_READY shall be 1.
REQ-035 Reset asserted mid-operation (FSM in WAIT, FIFO partially filled) shall discard all queued events.

Verification (bench HOLD_CYC = 8, FIFO_DEPTH = 4)
REQ-036 Push make 7'h2B (row 5, col 3) at edge t with STROBE = 1 and ROW_SEL = 5 -> COL_n = 8'hF7 at edge t+3, and ANY_KEY = 1 at edge t+3.
REQ-037 Push make 7'h2B then break 7'h2B back-to-back -> FSM enters WAIT; bit 3 stays pressed for at least 8 cycles after the make applies; COL_n returns to 8'hFF afterwards.
REQ-038 Hold EV_VALID = 1 for 6 events while the FSM is blocked in WAIT -> EV_READY drops after the 4th accepted event; the 5th and 6th are accepted only after pops; all 6 apply in order.
REQ-039 Press 3 keys, then pulse EV_CLR together with EV_VALID = 1 -> event not accepted; matrix = 0; ANY_KEY = 0 one edge later; FIFO empty.
REQ-040 STROBE = 0 with keys pressed -> COL_n = 8'hFF; ROW_SEL = 15 with key 7'h7F pressed and STROBE = 1 -> COL_n = 8'h7F.
REQ-041 Assert RST_n in WAIT with 2 queued events -> COL_n = 8'hFF and EV_READY = 0 immediately; after deassert, no queued event ever applies.

Source files
------------

// File: rtl/kbd_matrix_if.sv
// kbd_matrix_if: host key-event channel into the keyboard matrix.
// Valid/ready push plus a one-cycle clear/flush request.
interface kbd_matrix_if;
  logic       EV_VALID;
  logic       EV_READY;
  logic [6:0] EV_CODE;
  logic       EV_MAKE;
  logic       EV_CLR;

  modport master (
    output EV_VALID,
    output EV_CODE,
    output EV_MAKE,
    output EV_CLR,
    input  EV_READY
  );

  modport slave (
    input  EV_VALID,
    input  EV_CODE,
    input  EV_MAKE,
    input  EV_CLR,
    output EV_READY
  );
endinterface

// File: rtl/kbd_matrix.sv
// kbd_matrix: host-driven 16x8 key matrix behind an event FIFO.
// Breaks wait out a hold time so short taps are still scanned.
module kbd_matrix #(
  parameter logic [15:0] HOLD_CYC   = 16'd50000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST_n,
  kbd_matrix_if.slave  ev,
  input  logic [3:0]   ROW_SEL,
  input  logic         STROBE,
  output logic [7:0]   COL_n,
  output logic         ANY_KEY
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0][7:0] r_mat;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [15:0]      r_hold;
  logic             r_live;
  logic [7:0]       r_col;
  logic             r_any;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_set;
  logic       w_rel;
  logic       w_load;
  logic [7:0] w_head;
  logic [3:0] w_row;
  logic [2:0] w_col;
  logic       w_make;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

  // r_live keeps READY low until the first edge out of reset
  assign ev.EV_READY = r_live & ~w_full & ~ev.EV_CLR;
  assign w_push      = ev.EV_VALID & ev.EV_READY;

  assign w_head = r_mem[r_rp[AW-1:0]];
  assign w_row  = w_head[7:4];
  assign w_col  = w_head[3:1];
  assign w_make = w_head[0];

  assign COL_n   = r_col;
  assign ANY_KEY = r_any;

  // event storage, {code, make} per entry
  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wp[AW-1:0]] <= {ev.EV_CODE, ev.EV_MAKE};
  end

  // FIFO pointers with wrap bit; clear flushes
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (ev.EV_CLR) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n)
      r_state <= IDLE;
    else if (ev.EV_CLR)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // FSM next state and apply strobes
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_set  = 1'b0;
    w_rel  = 1'b0;
    w_load = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty)
          w_next = APPLY;
      end
      APPLY: begin
        if (w_make) begin
          w_set  = 1'b1;
          w_load = 1'b1;
          w_pop  = 1'b1;
          w_next = IDLE;
        end else if (r_hold == 16'd0) begin
          w_rel  = 1'b1;
          w_pop  = 1'b1;
          w_next = IDLE;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_hold <= 16'd1)
          w_next = APPLY;
      end
      default: w_next = IDLE;
    endcase
  end

  // hold counter: load on make, else count down to 0
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n)
      r_hold <= '0;
    else if (ev.EV_CLR)
      r_hold <= '0;
    else if (w_load)
      r_hold <= HOLD_CYC;
    else if (r_hold != 16'd0)
      r_hold <= r_hold - 16'd1;
  end

  // key matrix; repeated make/break is harmless
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n)
      r_mat <= '0;
    else if (ev.EV_CLR)
      r_mat <= '0;
    else if (w_set)
      r_mat[w_row][w_col] <= 1'b1;
    else if (w_rel)
      r_mat[w_row][w_col] <= 1'b0;
  end

  // scan outputs, ready gate
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      r_col  <= 8'hFF;
      r_any  <= 1'b0;
      r_live <= 1'b0;
    end else begin
      r_col  <= STROBE ? ~r_mat[ROW_SEL] : 8'hFF;
      r_any  <= |r_mat;
      r_live <= 1'b1;
    end
  end

endmodule
